// File: rtl/rtc_bus_cycle_if.sv
// Purpose: request/response and external-bus signal bundle for the RTC bus-cycle generator.
// Latency: none, this file only declares wires.
// Backpressure: none; a request made while busy is dropped by the generator.
//
// Signals
//   start, rw, addr, wdata : single-cycle request from the RTC controller FSM
//   busy, done, rdata      : cycle status and read result returned to the controller
//   AD_n, CS_n, RD_n, WR_n : active-low strobes to the RTC chip
//   bus_out, bus_oe        : value and enable for the multiplexed address/data pad
//   bus_in                 : value read back from the pad
//
// Modports
//   slave  : the bus-cycle generator's view
//   master : the controller/pad view, used by whoever drives requests and bus_in

interface rtc_bus_cycle_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       AD_n;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [7:0] bus_out;
  logic       bus_oe;

  modport slave (
    input  start, rw, addr, wdata, bus_in,
    output busy, done, rdata, AD_n, CS_n, RD_n, WR_n, bus_out, bus_oe
  );

  modport master (
    output start, rw, addr, wdata, bus_in,
    input  busy, done, rdata, AD_n, CS_n, RD_n, WR_n, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_bus_cycle.sv
// Purpose: turns a one-cycle read/write request into the RTC chip's address-strobe / data-strobe sequence.
// Latency: strobes start the cycle after start; done pulses 2*T_STROBE + 2*T_GAP + 1 cycles after start.
// Backpressure: busy is high for the whole sequence; start seen while busy is dropped, never queued.
//
// Ports
//   CLK    : system clock, rising edge
//   Reset  : synchronous, active-high
//   rtc    : rtc_bus_cycle_if.slave (request in, status/read data out, chip strobes and pad drive)
//
// Every output is a flop. The pin values for the state being entered are computed from that
// state (and the captured rw) and loaded on the same edge that makes the state change.

module rtc_bus_cycle #(
  parameter int unsigned T_STROBE = 4,  // cycles each strobe phase is held low, 1..255
  parameter int unsigned T_GAP    = 2   // recovery cycles after each strobe phase, 1..255
) (
  input logic          CLK,
  input logic          Reset,
  rtc_bus_cycle_if.slave rtc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_STB = 3'd1,
    A_GAP = 3'd2,
    D_STB = 3'd3,
    D_GAP = 3'd4
  } state_t;

  // Request captured with start; later changes on the request inputs are ignored.
  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  // Chip control pins plus pad enable, kept together so a phase sets them in one assignment.
  typedef struct packed {
    logic ad_n;
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic oe;
  } pins_t;

  // Terminal counts: a phase ends on the cycle where cnt equals its length minus one.
  localparam logic [7:0] STB_LAST = 8'(T_STROBE - 1);
  localparam logic [7:0] GAP_LAST = 8'(T_GAP - 1);

  localparam pins_t PINS_IDLE = '{ad_n: 1'b1, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, oe: 1'b0};

  state_t     state;
  req_t       req;
  pins_t      pins;
  logic [7:0] cnt;
  logic [7:0] bus_out;
  logic [7:0] rdata;
  logic       busy;
  logic       done;

  // Pin pattern for each phase. WR_n is low in the address phase as well as in a write data
  // phase; RD_n only ever goes low in a read data phase, so the two are never low together
  // and AD_n is never low alongside RD_n. A read leaves the pad undriven for the whole data
  // half of the cycle so the chip can turn the bus around.
  function automatic pins_t pins_for(state_t s, logic rd);
    pins_t p;
    p = PINS_IDLE;
    case (s)
      A_STB:   p = '{ad_n: 1'b0, cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, oe: 1'b1};
      A_GAP:   p = '{ad_n: 1'b1, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, oe: 1'b1};
      D_STB:   p = rd ? '{ad_n: 1'b1, cs_n: 1'b0, rd_n: 1'b0, wr_n: 1'b1, oe: 1'b0}
                      : '{ad_n: 1'b1, cs_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, oe: 1'b1};
      D_GAP:   p = '{ad_n: 1'b1, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, oe: ~rd};
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      req     <= '0;
      pins    <= PINS_IDLE;
      cnt     <= 8'd0;
      bus_out <= 8'h00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // This also covers the done cycle, so back-to-back requests lose no cycle.
          if (rtc.start) begin
            req     <= '{rw: rtc.rw, addr: rtc.addr, wdata: rtc.wdata};
            state   <= A_STB;
            cnt     <= 8'd0;
            busy    <= 1'b1;
            pins    <= pins_for(A_STB, rtc.rw);
            bus_out <= rtc.addr;
          end
        end

        A_STB: begin
          if (cnt == STB_LAST) begin
            state <= A_GAP;
            cnt   <= 8'd0;
            pins  <= pins_for(A_GAP, req.rw);
            // bus_out keeps the address through the recovery gap
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        A_GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= D_STB;
            cnt     <= 8'd0;
            pins    <= pins_for(D_STB, req.rw);
            bus_out <= req.rw ? 8'h00 : req.wdata;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        D_STB: begin
          if (cnt == STB_LAST) begin
            state <= D_GAP;
            cnt   <= 8'd0;
            pins  <= pins_for(D_GAP, req.rw);
            // Read data is taken on the edge that ends the strobe, while RD_n is still low.
            if (req.rw) begin
              rdata <= rtc.bus_in;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        D_GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            pins    <= PINS_IDLE;
            bus_out <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          // Unused encodings fall back to a quiet bus.
          state   <= IDLE;
          cnt     <= 8'd0;
          pins    <= PINS_IDLE;
          bus_out <= 8'h00;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign rtc.AD_n    = pins.ad_n;
  assign rtc.CS_n    = pins.cs_n;
  assign rtc.RD_n    = pins.rd_n;
  assign rtc.WR_n    = pins.wr_n;
  assign rtc.bus_oe  = pins.oe;
  assign rtc.bus_out = bus_out;
  assign rtc.rdata   = rdata;
  assign rtc.busy    = busy;
  assign rtc.done    = done;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Purpose: self-checking bench for rtc_bus_cycle; directed scenarios followed by random traffic.
// Latency: the reference model predicts each cycle's outputs from the transaction's age in cycles.
// Backpressure: random starts land while busy as well, and the model drops them the same way.

module tb_rtc_bus_cycle;
  localparam int TS    = 4;
  localparam int TG    = 2;
  localparam int TOTAL = 2 * TS + 2 * TG;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  rtc_bus_cycle_if bif ();

  rtc_bus_cycle #(.T_STROBE(TS), .T_GAP(TG)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .rtc   (bif)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: a transaction is described by its age, meaning cycles since it was
  // accepted. Age 1..TS is the address strobe, then TG gap cycles, TS data-strobe cycles
  // and TG gap cycles. After the final cycle comes one idle cycle with done set.
  bit         m_act  = 1'b0;
  int         m_age  = 0;
  bit         m_rw   = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  bit         m_done = 1'b0;

  function automatic logic [7:0] rb8();
    return 8'($urandom);
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic       a_stb, a_gap, d_stb, chk_bus;
    logic [6:0] exp_ctl;
    logic [7:0] exp_bus;
    if (!chk_en) return;
    a_stb = m_act && (m_age <= TS);
    a_gap = m_act && (m_age > TS) && (m_age <= TS + TG);
    d_stb = m_act && (m_age > TS + TG) && (m_age <= 2 * TS + TG);
    exp_ctl = {~a_stb,
               ~(a_stb | d_stb),
               ~(d_stb & m_rw),
               ~(a_stb | (d_stb & ~m_rw)),
               m_act & (a_stb | a_gap | ~m_rw),
               m_act,
               m_done};
    chk_eq("ctl", {bif.AD_n, bif.CS_n, bif.RD_n, bif.WR_n, bif.bus_oe, bif.busy, bif.done}, exp_ctl);
    chk_eq("rdata", bif.rdata, m_rdata);
    chk_bus = m_act && (a_stb || a_gap || d_stb || !m_rw);
    exp_bus = (a_stb || a_gap) ? m_addr : (m_rw ? 8'h00 : m_wdata);
    if (chk_bus) chk_eq("bus_out", bif.bus_out, exp_bus);
  endtask

  // One clock cycle: check the current cycle, apply inputs, advance the model, clock.
  // Entered and left at the falling edge.
  task automatic step(input bit st, input bit r, input logic [7:0] a, input logic [7:0] w,
                      input logic [7:0] bi, input bit rs);
    check_cycle();
    bif.start  = st;
    bif.rw     = r;
    bif.addr   = a;
    bif.wdata  = w;
    bif.bus_in = bi;
    Reset      = rs;
    if (rs) begin
      m_act   = 1'b0;
      m_age   = 0;
      m_rdata = 8'h00;
      m_done  = 1'b0;
    end else if (m_act) begin
      if (m_rw && m_age == 2 * TS + TG) m_rdata = bi;
      if (m_age == TOTAL) begin
        m_act  = 1'b0;
        m_done = 1'b1;
      end else begin
        m_age++;
      end
    end else begin
      m_done = 1'b0;
      if (st) begin
        m_act   = 1'b1;
        m_age   = 1;
        m_rw    = r;
        m_addr  = a;
        m_wdata = w;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_step();
    step(1'b0, 1'($urandom), rb8(), rb8(), rb8(), 1'b0);
  endtask

  initial begin
    int dones;
    bit saw55;
    bif.start = 1'b0; bif.rw = 1'b0; bif.addr = '0; bif.wdata = '0; bif.bus_in = '0;
    Reset = 1'b1;
    @(negedge CLK);

    // Reset held for two cycles
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk_en = 1'b1;
    chk_eq("rst_ctl", {bif.AD_n, bif.CS_n, bif.RD_n, bif.WR_n, bif.bus_oe, bif.busy, bif.done}, 7'b1111000);
    chk_eq("rst_rdata", bif.rdata, 8'h00);
    chk_eq("rst_bus_out", bif.bus_out, 8'h00);
    idle_step();

    // Write 0x15 to 0x21
    step(1'b1, 1'b0, 8'h21, 8'h15, rb8(), 1'b0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 2) chk_eq("wr_astb", {bif.AD_n, bif.CS_n, bif.WR_n, bif.bus_out}, {3'b000, 8'h21});
      if (i == 5) chk_eq("wr_agap", {bif.AD_n, bif.CS_n, bif.RD_n, bif.WR_n}, 4'hF);
      if (i == 8) chk_eq("wr_dstb", {bif.CS_n, bif.WR_n, bif.bus_oe, bif.bus_out}, {3'b001, 8'h15});
      if (i == 12) chk_eq("wr_dgap", {bif.AD_n, bif.CS_n, bif.RD_n, bif.WR_n}, 4'hF);
      idle_step();
    end
    chk_eq("wr_done", {bif.busy, bif.done}, 2'b01);

    // Read from 0x22, pad shows 0x37 during the data strobe; starts in the write's done cycle
    step(1'b1, 1'b1, 8'h22, rb8(), rb8(), 1'b0);
    for (int i = 1; i <= 12; i++) begin
      if (i == 9) chk_eq("rd_dstb", {bif.RD_n, bif.WR_n, bif.bus_oe}, 3'b010);
      step(1'b0, 1'($urandom), rb8(), rb8(), (i >= 7 && i <= 10) ? 8'h37 : rb8(), 1'b0);
    end
    chk_eq("rd_done", {bif.busy, bif.done, bif.rdata}, {1'b0, 1'b1, 8'h37});

    // A following write leaves rdata alone
    step(1'b1, 1'b0, 8'h23, 8'h44, rb8(), 1'b0);
    for (int i = 1; i <= 13; i++) idle_step();
    chk_eq("rd_keep", bif.rdata, 8'h37);

    // Start with addr 0x55 in cycle 3 of a write is dropped
    dones = 0;
    saw55 = 1'b0;
    step(1'b1, 1'b0, 8'h21, 8'h15, rb8(), 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (bif.done) dones++;
      if (bif.bus_oe && bif.bus_out == 8'h55) saw55 = 1'b1;
      step(i == 3, 1'b0, (i == 3) ? 8'h55 : rb8(), 8'h66, rb8(), 1'b0);
    end
    chk_eq("rej_dones", dones, 1);
    chk_eq("rej_no55", {31'd0, saw55}, 0);

    // start held high from cycle 0 through the first done cycle
    for (int i = 0; i <= 30; i++) begin
      if (i == 12) chk_eq("b2b_busy12", {bif.busy, bif.done}, 2'b10);
      if (i == 13) chk_eq("b2b_done1", {bif.busy, bif.done}, 2'b01);
      if (i == 14) chk_eq("b2b_astb2", {bif.AD_n, bif.busy}, 2'b01);
      if (i == 26) chk_eq("b2b_done2", {bif.busy, bif.done}, 2'b01);
      step(i <= 13, 1'b0, rb8(), rb8(), rb8(), 1'b0);
    end

    // Reset in cycle 8 of a read: quiet bus, rdata cleared, no done
    step(1'b1, 1'b1, 8'h30, rb8(), rb8(), 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, rb8(), rb8(), 8'h5A, i == 8);
    chk_eq("rstmid_ctl", {bif.AD_n, bif.CS_n, bif.RD_n, bif.WR_n, bif.bus_oe, bif.busy, bif.done}, 7'b1111000);
    chk_eq("rstmid_rdata", bif.rdata, 8'h00);
    dones = 0;
    for (int i = 9; i <= 16; i++) begin
      if (bif.done) dones++;
      idle_step();
    end
    chk_eq("rstmid_nodone", dones, 0);

    // Random traffic: frequent starts, occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), rb8(), rb8(), rb8(), $urandom_range(0, 199) == 0);
    end
    check_cycle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
